// File: rtl/riscv_cfg_shadow_regs.sv
// rtl/riscv_cfg_shadow_regs.sv - shadow/active configuration register bank with staged per-core commit
//
// A bus master reads/writes a shared shadow register set (plus a sticky LOCK register at
// index NUM_REGS). A commit copies the shadow set into the active set of every targeted
// core once that core reports quiescent, or gives up after TIMEOUT_CYCLES wait cycles.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   cfg_req_valid_i/ready_o/we_i/addr_i/wdata_i   register request (transfer on valid && ready)
//   cfg_rsp_valid_o/rdata_o/err_o      response, one cycle after the transfer
//   commit_req_i, commit_mask_i        commit pulse and target cores (sampled in IDLE)
//   core_quiescent_i                   per-core safe-to-update indication
//   commit_busy_o/done_o/timeout_o     commit status
//   active_cfg_o                       flattened active sets, core c reg r at (c*NUM_REGS+r)
//   parity_err_o                       sticky per-core active-set parity error
//
// Optional feature macro: RISCV_CFG_PARITY_EN (even parity per active register).
module riscv_cfg_shadow_regs #(
    parameter int                    NUM_CORES      = 1,
    parameter int                    NUM_REGS       = 8,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                    TIMEOUT_CYCLES = 1024,
    localparam int                   ADDR_W         = $clog2(NUM_REGS + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   cfg_req_valid_i,
    output logic                                   cfg_req_ready_o,
    input  logic                                   cfg_req_we_i,
    input  logic [ADDR_W-1:0]                      cfg_req_addr_i,
    input  logic [DATA_WIDTH-1:0]                  cfg_req_wdata_i,
    output logic                                   cfg_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                  cfg_rsp_rdata_o,
    output logic                                   cfg_rsp_err_o,
    input  logic                                   commit_req_i,
    input  logic [NUM_CORES-1:0]                   commit_mask_i,
    input  logic [NUM_CORES-1:0]                   core_quiescent_i,
    output logic                                   commit_busy_o,
    output logic                                   commit_done_o,
    output logic                                   commit_timeout_o,
    output logic [NUM_CORES*NUM_REGS*DATA_WIDTH-1:0] active_cfg_o,
    output logic [NUM_CORES-1:0]                   parity_err_o
);
    localparam int                ACT_W     = NUM_CORES * NUM_REGS * DATA_WIDTH;
    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, WAIT_QUIESCE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shadow_q [NUM_REGS];
    logic [ACT_W-1:0]       active_q;
    logic                   lock_q;
    logic [NUM_CORES-1:0]   pending_q;
    logic [NUM_CORES-1:0]   copy_en;
    logic [NUM_CORES-1:0]   still_pending;
    logic [CNT_W-1:0]       cnt_q;
    logic                   timeout_q;
    logic                   xfer;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_err;

    assign xfer = cfg_req_valid_i && cfg_req_ready_o;

    // Cores that take the shadow copy this cycle, and those left waiting afterwards.
    assign copy_en       = (state_q == WAIT_QUIESCE) ? (pending_q & core_quiescent_i) : '0;
    assign still_pending = pending_q & ~copy_en;

    // Response content for the request presented this cycle.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (cfg_req_addr_i < LOCK_ADDR) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (!cfg_req_we_i && cfg_req_addr_i == ADDR_W'(r)) rd_data = shadow_q[r];
            end
            if (cfg_req_we_i && lock_q) rd_err = 1'b1;
        end else if (cfg_req_addr_i == LOCK_ADDR) begin
            if (!cfg_req_we_i) rd_data = {{(DATA_WIDTH-1){1'b0}}, lock_q};
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        cfg_req_ready_o  = 1'b0;
        commit_busy_o    = 1'b1;
        commit_done_o    = 1'b0;
        commit_timeout_o = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_req_ready_o = 1'b1;
                commit_busy_o   = 1'b0;
                if (commit_req_i) state_d = (commit_mask_i == '0) ? DONE : WAIT_QUIESCE;
            end
            WAIT_QUIESCE: begin
                if (still_pending == '0 || cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                commit_done_o    = 1'b1;
                commit_timeout_o = timeout_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) shadow_q[r] <= RESET_VALUE;
            active_q    <= {(NUM_CORES*NUM_REGS){RESET_VALUE}};
            lock_q      <= 1'b0;
            pending_q   <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= xfer;
            rsp_err_q   <= xfer && rd_err;
            rsp_rdata_q <= xfer ? rd_data : '0;

            if (xfer && cfg_req_we_i) begin
                if (cfg_req_addr_i == LOCK_ADDR && cfg_req_wdata_i[0]) lock_q <= 1'b1;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (!lock_q && cfg_req_addr_i == ADDR_W'(r)) shadow_q[r] <= cfg_req_wdata_i;
                end
            end

            case (state_q)
                IDLE: begin
                    if (commit_req_i) begin
                        pending_q <= commit_mask_i;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                WAIT_QUIESCE: begin
                    pending_q <= still_pending;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST && still_pending != '0) timeout_q <= 1'b1;
                end
                default: ;
            endcase

            // A commit in the same cycle as a shadow write copies in the next cycle, so the
            // copy naturally sees the freshly written value.
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (copy_en[c]) active_q[(c*NUM_REGS+r)*DATA_WIDTH +: DATA_WIDTH] <= shadow_q[r];
                end
            end
        end
    end

    assign cfg_rsp_valid_o = rsp_valid_q;
    assign cfg_rsp_err_o   = rsp_err_q;
    assign cfg_rsp_rdata_o = rsp_rdata_q;
    assign active_cfg_o    = active_q;

`ifdef RISCV_CFG_PARITY_EN
    logic [NUM_CORES*NUM_REGS-1:0] par_q;
    logic [NUM_CORES-1:0]          par_mismatch;
    logic [NUM_CORES-1:0]          parity_err_q;

    always_comb begin
        par_mismatch = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if ((^active_q[(c*NUM_REGS+r)*DATA_WIDTH +: DATA_WIDTH]) != par_q[c*NUM_REGS+r])
                    par_mismatch[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_q        <= {(NUM_CORES*NUM_REGS){^RESET_VALUE}};
            parity_err_q <= '0;
        end else begin
            parity_err_q <= parity_err_q | par_mismatch;
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (copy_en[c]) par_q[c*NUM_REGS+r] <= ^shadow_q[r];
                end
            end
        end
    end

    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = '0;
`endif

endmodule
